// File: rtl/spike_dec_pkg.sv
// rtl/spike_dec_pkg.sv - shared types and constants for the spike train decoder
//
// Purpose: FSM state type, default widths, and helpers that produce the
// saturation maxima and the last-window-cycle comparison value.
package spike_dec_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int CNT_WIDTH_DEF = 8;
  localparam int ISI_WIDTH_DEF = 8;
  localparam int WIN_LOG2_DEF  = 6;

  // All-ones value of a w-bit saturating counter.
  function automatic logic [31:0] sat_max(input int w);
    return (32'h1 << w) - 32'h1;
  endfunction

  // Index of the last cycle of a 2^log2-cycle window.
  function automatic logic [31:0] win_last(input int log2);
    return (32'h1 << log2) - 32'h1;
  endfunction

endpackage

// File: rtl/spike_train_decoder_if.sv
// rtl/spike_train_decoder_if.sv - result handshake bundle of the spike train decoder
//
// Purpose: groups the valid/ready result register outputs.
// Signals: out_valid, out_count, out_isi, out_drop (producer -> consumer),
//          out_ready (consumer -> producer).
// Modports: master = decoder side, slave = readout side.
interface spike_train_decoder_if #(
  parameter int CNT_WIDTH = 8,
  parameter int ISI_WIDTH = 8
);
  logic                 out_valid;
  logic                 out_ready;
  logic [CNT_WIDTH-1:0] out_count;
  logic [ISI_WIDTH-1:0] out_isi;
  logic                 out_drop;

  modport master (
    output out_valid, out_count, out_isi, out_drop,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_count, out_isi, out_drop,
    output out_ready
  );
endinterface

// File: rtl/spike_edge_detect.sv
// rtl/spike_edge_detect.sv - optional synchronizer plus rising-edge detector
//
// Purpose: turns the spike level into a one-cycle pulse per rising edge.
// Ports: clk, reset (async, active high), spike_in (level), spike_edge (pulse).
// Macro SPIKE_DEC_SYNC_EN: adds a two-flop synchronizer ahead of the detector,
// delaying every edge by two cycles.
module spike_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic spike_in,
  output logic spike_edge
);

  logic spike_src;
  logic spike_d, spike_q;

`ifdef SPIKE_DEC_SYNC_EN
  logic sync1_d, sync1_q, sync2_d, sync2_q;

  always_comb begin
    sync1_d = spike_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign spike_src = sync2_q;
`else
  assign spike_src = spike_in;
`endif

  always_comb spike_d = spike_src;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) spike_q <= 1'b0;
    else       spike_q <= spike_d;
  end

  // A line held high yields one pulse: spike_q catches up after one cycle.
  assign spike_edge = spike_src & ~spike_q;

endmodule

// File: rtl/spike_train_decoder.sv
// rtl/spike_train_decoder.sv - decodes a spike line into per-window rate and ISI
//
// Purpose: counts rising edges per 2^WIN_LOG2-cycle window and tracks the
// latest inter-spike interval, publishing both through a valid/ready register.
// Ports: clk, reset (async, active high), enable, spike_in, busy (in RUN),
//        out_if (master: out_valid/out_ready/out_count/out_isi/out_drop).
// Macro SPIKE_DEC_SYNC_EN: synchronizes spike_in before edge detection.
module spike_train_decoder
  import spike_dec_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int ISI_WIDTH = ISI_WIDTH_DEF,
  parameter int WIN_LOG2  = WIN_LOG2_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         spike_in,
  output logic                         busy,
  spike_train_decoder_if.master        out_if
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(sat_max(CNT_WIDTH));
  localparam logic [ISI_WIDTH-1:0] ISI_MAX  = ISI_WIDTH'(sat_max(ISI_WIDTH));
  localparam logic [WIN_LOG2-1:0]  WIN_LAST = WIN_LOG2'(win_last(WIN_LOG2));

  logic spike_edge;

  spike_edge_detect u_edge (
    .clk       (clk),
    .reset     (reset),
    .spike_in  (spike_in),
    .spike_edge(spike_edge)
  );

  state_e               state_d, state_q;
  logic [WIN_LOG2-1:0]  win_cnt_d, win_cnt_q;
  logic [CNT_WIDTH-1:0] spk_cnt_d, spk_cnt_q;
  logic [ISI_WIDTH-1:0] isi_cnt_d, isi_cnt_q;
  logic [ISI_WIDTH-1:0] isi_reg_d, isi_reg_q;
  logic                 have_prev_d, have_prev_q;
  logic                 out_valid_d, out_valid_q;
  logic [CNT_WIDTH-1:0] out_count_d, out_count_q;
  logic [ISI_WIDTH-1:0] out_isi_d, out_isi_q;
  logic                 out_drop_d, out_drop_q;

  // Values including this cycle's edge, so a last-cycle edge lands in the closing window.
  logic [CNT_WIDTH-1:0] spk_next;
  logic [ISI_WIDTH-1:0] isi_reg_next;
  logic                 xfer;

  always_comb begin
    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    spk_cnt_d    = spk_cnt_q;
    isi_cnt_d    = isi_cnt_q;
    isi_reg_d    = isi_reg_q;
    have_prev_d  = have_prev_q;
    out_valid_d  = out_valid_q;
    out_count_d  = out_count_q;
    out_isi_d    = out_isi_q;
    out_drop_d   = out_drop_q;
    spk_next     = spk_cnt_q;
    isi_reg_next = isi_reg_q;

    // Handshake runs in every state; a window close below may reload at once.
    xfer = out_valid_q & out_if.out_ready;
    if (xfer) begin
      out_valid_d = 1'b0;
      out_drop_d  = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        win_cnt_d   = '0;
        spk_cnt_d   = '0;
        isi_cnt_d   = '0;
        isi_reg_d   = '0;
        have_prev_d = 1'b0;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          // Abort: the partial window and all interval history are dropped.
          state_d     = IDLE;
          win_cnt_d   = '0;
          spk_cnt_d   = '0;
          isi_cnt_d   = '0;
          isi_reg_d   = '0;
          have_prev_d = 1'b0;
        end else begin
          win_cnt_d = win_cnt_q + 1'b1;
          if (spike_edge) begin
            if (spk_cnt_q != CNT_MAX) spk_next = spk_cnt_q + 1'b1;
            if (have_prev_q) isi_reg_next = isi_cnt_q;
            isi_cnt_d   = ISI_WIDTH'(1);
            have_prev_d = 1'b1;
          end else if (isi_cnt_q != ISI_MAX) begin
            isi_cnt_d = isi_cnt_q + 1'b1;
          end
          isi_reg_d = isi_reg_next;
          spk_cnt_d = spk_next;

          if (win_cnt_q == WIN_LAST) begin
            spk_cnt_d = '0;
            if (!out_valid_q || xfer) begin
              out_valid_d = 1'b1;
              out_count_d = spk_next;
              out_isi_d   = isi_reg_next;
            end else begin
              out_drop_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      win_cnt_q   <= '0;
      spk_cnt_q   <= '0;
      isi_cnt_q   <= '0;
      isi_reg_q   <= '0;
      have_prev_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_isi_q   <= '0;
      out_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      spk_cnt_q   <= spk_cnt_d;
      isi_cnt_q   <= isi_cnt_d;
      isi_reg_q   <= isi_reg_d;
      have_prev_q <= have_prev_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_isi_q   <= out_isi_d;
      out_drop_q  <= out_drop_d;
    end
  end

  assign busy             = (state_q == RUN);
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_count = out_count_q;
  assign out_if.out_isi   = out_isi_q;
  assign out_if.out_drop  = out_drop_q;

endmodule

// File: doc/spike_train_decoder.md
Name: spike_train_decoder

Overview:
Receiver end of the neuron spike interface. It takes a spike line from an LIF neuron, such as the spike1/spike2 outputs, and decodes it back into numbers. For each fixed window it reports a spike count (rate code) and the most recent inter-spike interval (temporal code). Results leave through a valid/ready output register, so a readout or host-interface block can sample neuron activity without tracking individual spikes.

Parameters:
CNT_WIDTH, 8, width of the per-window spike count; saturating.
ISI_WIDTH, 8, width of the inter-spike-interval measurement; saturating.
WIN_LOG2, 6, window length is 2^WIN_LOG2 clock cycles.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  1 = decode windows, 0 = idle.
spike_in  input  1  spike line, level; each rising edge counts as one spike.
out_ready  input  1  consumer accepts the result.
out_valid  output  1  result register holds an unconsumed result.
out_count  output  CNT_WIDTH  rising edges counted in the reported window.
out_isi  output  ISI_WIDTH  latest interval between consecutive edges at window close; 0 if fewer than two edges since enable rose.
out_drop  output  1  sticky: at least one window result was discarded since the last handshake.
busy  output  1  1 while in RUN.

Behaviour:
- Clock and reset: one clock (clk). Asynchronous active-high reset (reset) clears every register, including all outputs.
- Reset values: out_valid=0, out_count=0, out_isi=0, out_drop=0, busy=0, state=IDLE.
- Edge detect: spike_q <= spike_in every cycle, in all states. edge = spike_in & ~spike_q. A line held high produces exactly one edge.
- States:
  - IDLE: win_cnt=0, spk_cnt=0, isi_cnt=0, have_prev=0.
  - IDLE -> RUN when enable=1. The first window cycle is the cycle after the transition.
  - RUN: win_cnt increments each cycle, wrapping at 2^WIN_LOG2-1.
  - RUN -> IDLE when enable=0, in any cycle. The partial window is discarded; the output register, out_valid and out_drop are untouched.
- Spike count: in RUN, an edge adds 1 to spk_cnt, saturating at 2^CNT_WIDTH-1. An edge on the last window cycle belongs to the closing window.
- ISI measurement:
  - On an edge, isi_cnt <= 1. Otherwise isi_cnt increments, saturating at 2^ISI_WIDTH-1.
  - On an edge with have_prev=1, isi_reg <= isi_cnt. Example: edges at cycles t and t+3 give isi_reg=3.
  - On any edge, have_prev <= 1.
  - isi_cnt, isi_reg and have_prev persist across window boundaries and clear only in IDLE or on reset.
- Window close: on the last window cycle (win_cnt = 2^WIN_LOG2-1):
  - The result is {spk_cnt including this cycle's edge, isi_reg including this cycle's update}.
  - spk_cnt restarts at 0 for the next window, with no gap cycle.
  - Load rule: if out_valid=0, or out_valid&out_ready in this same cycle, load the output register and set out_valid=1 next cycle. Otherwise discard the new result, keep the old one, and set out_drop=1.
- Latency: out_valid rises on the cycle after the last window cycle, 2^WIN_LOG2+1 cycles after enable is first sampled high.
- Handshake:
  - out_valid, out_count, out_isi and out_drop stay stable while out_valid=1 and out_ready=0.
  - Transfer happens when out_valid&out_ready. out_valid clears unless a new result loads in the same cycle.
  - out_drop clears on transfer; it is reported with the transferred result.
- Reset mid-window or mid-handshake: the pending result is lost and the outputs go to their reset values.

Optional Feature:
SPIKE_DEC_SYNC_EN
- Defined: spike_in passes through a two-flop synchronizer before the edge detector, for asynchronous or off-chip spike sources. Every edge is seen 2 cycles later, and window alignment is unchanged, so an edge in the last 2 window cycles counts in the next window. Synchronizer flops reset to 0.
- Undefined: spike_in goes straight to the edge detector. Spike sources must then be clk-synchronous, as the on-chip neurons are.

Decomposition:
- Package spike_dec_pkg:
  - State enum {IDLE, RUN}.
  - Saturation helper constants for CNT_WIDTH and ISI_WIDTH maxima.
  - Window-last comparison constant.
- Sub-module spike_edge_detect: optional synchronizer plus rising-edge detector; outputs a one-cycle edge pulse.
- Everything else (counters, FSM, output register) lives in the top module.

Test Plan:
- Reset: assert reset for 3 cycles with spike_in toggling -> all outputs 0, busy=0; after release with enable=0, out_valid stays 0 indefinitely.
- Periodic spikes: enable=1, out_ready=1, one-cycle pulses every 4 cycles starting on window cycle 0 -> out_valid pulses for 1 cycle at cycle 65 with out_count=16, out_isi=4, out_drop=0; repeats every 64 cycles.
- Held high: spike_in rises on window cycle 10 and stays high -> out_count=1, out_isi=0; next window out_count=0, out_isi=0.
- Backpressure: out_ready=0 for three window closes -> first result held stable, out_drop=1 after the second close; then out_ready=1 for 1 cycle -> first result transfers with out_drop=1, out_valid falls, out_drop clears.
- Saturation and enable abort:
  - CNT_WIDTH=4, pulses every 2 cycles -> out_count=15, out_isi=2.
  - Separate run: deassert enable at window cycle 30 -> no out_valid; re-enable -> a full fresh window, with no ISI carried over from before the abort.
- Build with SPIKE_DEC_SYNC_EN: repeat the periodic test -> identical results; a pulse on window cycle 63 is counted in the following window.
